cond_code_reg: RTL and testbench

- Execute-stage condition-code (CC) register for the pipelined 64-bit core.
- Sits directly downstream of the Execute adder/ALU and consumes its 3-bit flag vector {OF, SF, ZF}.
- Latches the flags when the Execute instruction is allowed to set them.
- Evaluates the branch/cmov condition e_cnd from the registered flags for the instruction currently in Execute.

---
 rtl/cc_if.sv | 34 +++
 rtl/cond_code_reg.sv | 87 ++++++++
 tb/tb_cond_code_reg.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cc_if.sv
// Execute-stage CC bus between the pipeline (master) and the condition-code register (slave).
// With CC_UPDATE_CNT_EN defined, the bus also carries the accepted-update counter cc_upd_cnt.
interface cc_if;
    localparam int unsigned CC_W   = 3;
    localparam int unsigned IFUN_W = 4;
    localparam int unsigned CNT_W  = 32;

    logic              set_cc;
    logic              m_exc;
    logic              w_exc;
    logic [CC_W-1:0]   alu_cf;
    logic [IFUN_W-1:0] e_ifun;
    logic [CC_W-1:0]   cc_out;
    logic              e_cnd;
`ifdef CC_UPDATE_CNT_EN
    logic [CNT_W-1:0]  cc_upd_cnt;
`endif

    modport master (
        output set_cc, m_exc, w_exc, alu_cf, e_ifun,
`ifdef CC_UPDATE_CNT_EN
        input  cc_upd_cnt,
`endif
        input  cc_out, e_cnd
    );

    modport slave (
        input  set_cc, m_exc, w_exc, alu_cf, e_ifun,
`ifdef CC_UPDATE_CNT_EN
        output cc_upd_cnt,
`endif
        output cc_out, e_cnd
    );
endinterface

// File: rtl/cond_code_reg.sv
// Execute-stage condition-code register {OF,SF,ZF} and branch/cmov condition evaluation.
// Optional macro CC_UPDATE_CNT_EN adds a 32-bit count of accepted CC updates.
module cond_code_reg #(
    parameter int unsigned    CCW    = 3,
    parameter logic [CCW-1:0] CC_RST = 3'b001
) (
    input  logic clk,
    input  logic rst,
    cc_if.slave  cc_bus
);
    localparam int unsigned ZF_BIT = 0;
    localparam int unsigned SF_BIT = 1;
    localparam int unsigned OF_BIT = 2;
    localparam int unsigned CNT_W  = 32;

    logic           upd;
    logic [CCW-1:0] cc_d;
    logic [CCW-1:0] cc_q;

    // A fault held by an older instruction in M or W freezes the architectural flags.
    assign upd = cc_bus.set_cc & ~cc_bus.m_exc & ~cc_bus.w_exc;

    always_comb begin
        cc_d = cc_q;
        if (upd) begin
            cc_d = cc_bus.alu_cf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cc_q <= CC_RST;
        end else begin
            cc_q <= cc_d;
        end
    end

    assign cc_bus.cc_out = cc_q;

    // Condition uses registered flags only; this cycle's alu_cf is never bypassed.
    logic zf;
    logic lt;
    logic cnd;

    assign zf = cc_q[ZF_BIT];
    assign lt = cc_q[SF_BIT] ^ cc_q[OF_BIT];

    always_comb begin
        cnd = 1'b0;
        case (cc_bus.e_ifun)
            4'd0:    cnd = 1'b1;
            4'd1:    cnd = lt | zf;
            4'd2:    cnd = lt;
            4'd3:    cnd = zf;
            4'd4:    cnd = ~zf;
            4'd5:    cnd = ~lt;
            4'd6:    cnd = ~lt & ~zf;
            default: cnd = 1'b0;
        endcase
    end

    assign cc_bus.e_cnd = cnd;

`ifdef CC_UPDATE_CNT_EN
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Wraps naturally from all-ones to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (upd) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cc_bus.cc_upd_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_cond_code_reg.sv
// Directed scoreboard bench for cond_code_reg; counter checks compile in with CC_UPDATE_CNT_EN.
module tb_cond_code_reg;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cc_if bus ();
    cond_code_reg dut (.clk(clk), .rst(rst), .cc_bus(bus));

    typedef struct packed {
        logic [2:0]  cc;
        logic        cnd;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    logic [2:0]  m_cc;
    logic [31:0] m_cnt;
    bit          m_valid = 1'b0;
    int          checks  = 0;
    int          errors  = 0;

    // Reference condition table written from the selector list.
    function automatic logic ref_cnd(input logic [2:0] f, input logic [3:0] fn);
        logic z, s, o;
        z = f[0]; s = f[1]; o = f[2];
        if (fn == 4'd0) return 1'b1;
        if (fn == 4'd1) return (s != o) || z;
        if (fn == 4'd2) return (s != o);
        if (fn == 4'd3) return z;
        if (fn == 4'd4) return !z;
        if (fn == 4'd5) return (s == o);
        if (fn == 4'd6) return (s == o) && !z;
        return 1'b0;
    endfunction

    // Drive one cycle at negedge, check the in-cycle outputs, then advance the model past the edge.
    task automatic step(input logic r, input logic sc, input logic me, input logic we,
                        input logic [2:0] cf, input logic [3:0] fn, input string tag);
        exp_t e;
        @(negedge clk);
        rst = r; bus.set_cc = sc; bus.m_exc = me; bus.w_exc = we;
        bus.alu_cf = cf; bus.e_ifun = fn;
        if (m_valid) begin
            e.cc = m_cc; e.cnd = ref_cnd(m_cc, fn); e.cnt = m_cnt;
            sb.push_back(e);
        end
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            assert (bus.cc_out === e.cc) else begin
                errors++;
                $error("FAIL %s cc_out observed=%b expected=%b", tag, bus.cc_out, e.cc);
            end
            checks++;
            assert (bus.e_cnd === e.cnd) else begin
                errors++;
                $error("FAIL %s e_cnd observed=%b expected=%b", tag, bus.e_cnd, e.cnd);
            end
`ifdef CC_UPDATE_CNT_EN
            checks++;
            assert (bus.cc_upd_cnt === e.cnt) else begin
                errors++;
                $error("FAIL %s cc_upd_cnt observed=%h expected=%h", tag, bus.cc_upd_cnt, e.cnt);
            end
`endif
        end
        if (r) begin
            m_cc = 3'b001; m_cnt = 32'd0; m_valid = 1'b1;
        end else if (sc && !me && !we) begin
            m_cc = cf; m_cnt = m_cnt + 32'd1;
        end
    endtask

    initial begin
        rst = 1'b1; bus.set_cc = 1'b0; bus.m_exc = 1'b0; bus.w_exc = 1'b0;
        bus.alu_cf = 3'b000; bus.e_ifun = 4'd0;

        // reset for two cycles
        step(1, 0, 0, 0, 3'b000, 4'd0, "rst0");
        step(1, 0, 0, 0, 3'b000, 4'd0, "rst1");
        step(0, 0, 0, 0, 3'bxxx, 4'd3, "rst_e");
        step(0, 0, 0, 0, 3'bxxx, 4'd4, "rst_ne");
        step(0, 0, 0, 0, 3'b000, 4'd0, "rst_always");

        // basic latch SF=1
        step(0, 1, 0, 0, 3'b010, 4'd0, "latch_sf");
        step(0, 0, 0, 0, 3'bxxx, 4'd2, "sf_l");
        step(0, 0, 0, 0, 3'bxxx, 4'd5, "sf_ge");
        step(0, 0, 0, 0, 3'bxxx, 4'd6, "sf_g");
        step(0, 0, 0, 0, 3'bxxx, 4'd1, "sf_le");

        // OF=SF=1 -> lt=0
        step(0, 1, 0, 0, 3'b110, 4'd0, "load_of");
        step(0, 0, 0, 0, 3'bxxx, 4'd1, "of_le");
        step(0, 0, 0, 0, 3'bxxx, 4'd5, "of_ge");
        step(0, 0, 0, 0, 3'bxxx, 4'd6, "of_g");

        // suppression by M and W exceptions
        step(0, 1, 0, 0, 3'b001, 4'd0, "load_zf");
        step(0, 1, 1, 0, 3'b100, 4'd3, "sup_m");
        step(0, 1, 0, 1, 3'b100, 4'd3, "sup_w");
        step(0, 1, 1, 1, 3'b100, 4'd2, "sup_mw");
        step(0, 0, 0, 0, 3'bxxx, 4'd3, "sup_after");

        // no bypass: old ZF in cycle N, new flags in N+1
        step(0, 1, 0, 0, 3'b000, 4'd3, "nobyp_n");
        step(0, 0, 0, 0, 3'bxxx, 4'd3, "nobyp_n1");

        // undefined selectors for several flag states
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 0, 0, 3'(k), 4'd9, "undef_load");
            for (int f = 7; f < 16; f++) begin
                step(0, 0, 0, 0, 3'bxxx, 4'(f), "undef_sel");
            end
        end

        // all selectors on a mixed flag state
        step(0, 1, 0, 0, 3'b101, 4'd0, "load_mix");
        for (int f = 0; f < 7; f++) begin
            step(0, 0, 0, 0, 3'bxxx, 4'(f), "mix_sel");
        end

        // reset priority over an update
        step(0, 1, 0, 0, 3'b110, 4'd0, "pre_rst");
        step(1, 1, 0, 0, 3'b000, 4'd3, "rst_prio");
        step(0, 0, 0, 0, 3'bxxx, 4'd3, "post_rst");

`ifdef CC_UPDATE_CNT_EN
        step(0, 1, 0, 0, 3'b010, 4'd0, "cnt_a");
        step(0, 0, 0, 0, 3'bxxx, 4'd0, "cnt_b");
        @(negedge clk);
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        step(0, 1, 0, 0, 3'b100, 4'd2, "wrap_upd");
        step(0, 1, 1, 0, 3'b011, 4'd2, "wrap_chk");
`endif

        step(0, 0, 0, 0, 3'bxxx, 4'd0, "final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
